// File: rtl/rr_arb_mux_4_1.sv
// rr_arb_mux_4_1: four-source round-robin stream arbiter driving a registered 4:1 data mux.
// Define ARB_LOCK_EN to hold the grant on one source until it sends a beat with in_last set.
module rr_arb_mux_4_1 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_valid,
    input  logic [3:0]   in_last,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    output logic [3:0]   in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel,
    output logic         out_last
);
    // Handshake: a word moves when valid && ready are both high at a rising edge.
    // Sources hold valid and data until accepted; out_* are held while out_valid && !out_ready.

    logic [1:0]   r_ptr;
    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic [1:0]   r_out_sel;
    logic         r_out_last;

    logic [7:0]   w_dbl;
    logic [3:0]   w_rot;
    logic [1:0]   w_off;
    logic [1:0]   w_rr_gnt;
    logic [1:0]   w_gnt;
    logic         w_req;
    logic         w_accept;
    logic         w_xfer;
    logic [3:0]   w_ready;
    logic [W-1:0] w_gnt_data;

`ifdef ARB_LOCK_EN
    logic         r_lock;
    logic [1:0]   r_lock_idx;
`endif

    // Rotate requests so bit 0 is the highest-priority source, then priority-encode.
    assign w_dbl = {in_valid, in_valid};
    assign w_rot = w_dbl[r_ptr +: 4];

    always_comb begin
        w_off = 2'd3;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
    end

    assign w_rr_gnt = r_ptr + w_off;

`ifdef ARB_LOCK_EN
    assign w_gnt = r_lock ? r_lock_idx : w_rr_gnt;
    assign w_req = r_lock ? in_valid[r_lock_idx] : (|in_valid);
`else
    assign w_gnt = w_rr_gnt;
    assign w_req = |in_valid;
`endif

    assign w_accept = !r_out_valid || out_ready;
    assign w_ready  = (rst_n && w_accept && w_req) ? (4'b0001 << w_gnt) : 4'b0000;
    assign w_xfer   = |w_ready;

    always_comb begin
        w_gnt_data = in_data0;
        case (w_gnt)
            2'd0: w_gnt_data = in_data0;
            2'd1: w_gnt_data = in_data1;
            2'd2: w_gnt_data = in_data2;
            2'd3: w_gnt_data = in_data3;
            default: w_gnt_data = in_data0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= 2'd0;
            r_out_last  <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_sel   <= w_gnt;
            r_out_last  <= in_last[w_gnt];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Pointer moves past the winner only on a transfer (on the last beat when locking).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= 2'd0;
`ifdef ARB_LOCK_EN
            r_lock     <= 1'b0;
            r_lock_idx <= 2'd0;
`endif
        end else if (w_xfer) begin
`ifdef ARB_LOCK_EN
            if (in_last[w_gnt]) begin
                r_ptr  <= w_gnt + 2'd1;
                r_lock <= 1'b0;
            end else begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_gnt;
            end
`else
            r_ptr <= w_gnt + 2'd1;
`endif
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// tb_rr_arb_mux_4_1: vector table, hand-written corner sequences and a randomized run
// against a round-robin reference model for rr_arb_mux_4_1 (default build).
module tb_rr_arb_mux_4_1;
    logic       clk;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [3:0] in_last;
    logic [3:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0] in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_sel;
    logic       out_last;

    int checks   = 0;
    int failures = 0;

    rr_arb_mux_4_1 #(.W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_last(in_last),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel), .out_last(out_last)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_sel;
        logic [3:0] exp_data;
        logic       exp_last;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic [3:0] iv, logic ordy, logic [3:0] rdy, logic ov,
                                 logic [1:0] sel, logic [3:0] d, logic l);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.exp_rdy = rdy; v.exp_ov = ov;
        v.exp_sel = sel; v.exp_data = d; v.exp_last = l;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 4'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Reference model state: priority pointer and the output register.
    int         m_ptr;
    logic       m_ov;
    logic [3:0] m_od;
    logic [1:0] m_os;
    logic       m_ol;

    function automatic int model_grant(logic [3:0] iv, int ptr);
        int g;
        g = -1;
        for (int k = 0; k < 4; k++)
            if (g < 0 && iv[(ptr + k) % 4]) g = (ptr + k) % 4;
        return g;
    endfunction

    logic [3:0] dat [4];
    logic [3:0] lst;
    logic [3:0] pend;

    initial begin
        rst_n = 1'b0;
        in_valid = 4'b1111;
        in_last = 4'b0;
        out_ready = 1'b1;
        in_data0 = 4'd1; in_data1 = 4'd2; in_data2 = 4'd3; in_data3 = 4'd4;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 4'h0);
        chk("reset_out_sel", out_sel, 2'd0);
        chk("reset_out_last", out_last, 1'b0);
        chk("reset_in_ready", in_ready, 4'b0000);
        in_valid = 4'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: data i = i+1, in_last = 4'b0101, pointer starts at 0.
        in_last = 4'b0101;
        vecs.push_back(mkv(4'b1111, 1, 4'b0001, 1, 0, 4'd1, 1));
        vecs.push_back(mkv(4'b1111, 1, 4'b0010, 1, 1, 4'd2, 0));
        vecs.push_back(mkv(4'b1111, 1, 4'b0100, 1, 2, 4'd3, 1));
        vecs.push_back(mkv(4'b1111, 1, 4'b1000, 1, 3, 4'd4, 0));
        vecs.push_back(mkv(4'b1111, 1, 4'b0001, 1, 0, 4'd1, 1));
        vecs.push_back(mkv(4'b1111, 0, 4'b0000, 1, 0, 4'd1, 1));
        vecs.push_back(mkv(4'b1111, 0, 4'b0000, 1, 0, 4'd1, 1));
        vecs.push_back(mkv(4'b1111, 0, 4'b0000, 1, 0, 4'd1, 1));
        vecs.push_back(mkv(4'b1111, 1, 4'b0010, 1, 1, 4'd2, 0));
        vecs.push_back(mkv(4'b1000, 1, 4'b1000, 1, 3, 4'd4, 0));
        vecs.push_back(mkv(4'b1001, 1, 4'b0001, 1, 0, 4'd1, 1));
        vecs.push_back(mkv(4'b1001, 1, 4'b1000, 1, 3, 4'd4, 0));
        vecs.push_back(mkv(4'b0000, 1, 4'b0000, 0, 3, 4'd4, 0));
        vecs.push_back(mkv(4'b0100, 1, 4'b0100, 1, 2, 4'd3, 1));
        vecs.push_back(mkv(4'b0000, 1, 4'b0000, 0, 2, 4'd3, 1));
        vecs.push_back(mkv(4'b0001, 0, 4'b0001, 1, 0, 4'd1, 1));
        vecs.push_back(mkv(4'b0000, 0, 4'b0000, 1, 0, 4'd1, 1));
        vecs.push_back(mkv(4'b0000, 1, 4'b0000, 0, 0, 4'd1, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = vecs[i].iv;
            out_ready = vecs[i].ordy;
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, vecs[i].exp_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), out_valid, vecs[i].exp_ov);
            chk($sformatf("tbl%0d_out_sel", i), out_sel, vecs[i].exp_sel);
            chk($sformatf("tbl%0d_out_data", i), out_data, vecs[i].exp_data);
            chk($sformatf("tbl%0d_out_last", i), out_last, vecs[i].exp_last);
        end

        // Reset asserted while a word is held
        in_valid = 4'b0010;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_pre_valid", out_valid, 1'b1);
        in_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_sel", out_sel, 2'd0);
        chk("midrst_out_data", out_data, 4'h0);
        chk("midrst_in_ready", in_ready, 4'b0000);
        in_valid = 4'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single source 2 with data 0xA
        in_data2 = 4'hA;
        in_valid = 4'b0100;
        out_ready = 1'b1;
        @(negedge clk);
        chk("single_in_ready", in_ready, 4'b0100);
        @(posedge clk);
        #1;
        chk("single_out_valid", out_valid, 1'b1);
        chk("single_out_data", out_data, 4'hA);
        chk("single_out_sel", out_sel, 2'd2);
        in_valid = 4'b0;

        // Without packet lock, source 1 beats interleave with sources 2 and 0
        do_reset();
        out_ready = 1'b1;
        in_last = 4'b0000;
        in_valid = 4'b0001;
        @(posedge clk);
        #1;
        in_valid = 4'b0111;
        @(posedge clk);
        #1;
        chk("nolock_sel_a", out_sel, 2'd1);
        @(posedge clk);
        #1;
        chk("nolock_sel_b", out_sel, 2'd2);
        @(posedge clk);
        #1;
        chk("nolock_sel_c", out_sel, 2'd0);

        // Randomized run against the reference model
        do_reset();
        m_ptr = 0; m_ov = 1'b0; m_od = 4'h0; m_os = 2'd0; m_ol = 1'b0;
        pend = 4'b0;
        for (int c = 0; c < 400; c++) begin
            int g;
            logic [3:0] exp_rdy;
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    dat[i] = 4'($urandom);
                    lst[i] = 1'($urandom);
                end
            end
            in_valid = pend;
            in_last = lst;
            in_data0 = dat[0]; in_data1 = dat[1]; in_data2 = dat[2]; in_data3 = dat[3];
            out_ready = ($urandom_range(0, 3) != 0);
            g = model_grant(pend, m_ptr);
            exp_rdy = 4'b0;
            if ((!m_ov || out_ready) && g >= 0) exp_rdy[g] = 1'b1;
            @(negedge clk);
            chk("rand_in_ready", in_ready, exp_rdy);
            if (exp_rdy != 4'b0) begin
                m_ov = 1'b1;
                m_od = dat[g];
                m_os = 2'(g);
                m_ol = lst[g];
                m_ptr = (g + 1) % 4;
                pend[g] = 1'b0;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("rand_out_valid", out_valid, m_ov);
            if (m_ov) begin
                chk("rand_out_data", out_data, m_od);
                chk("rand_out_sel", out_sel, m_os);
                chk("rand_out_last", out_last, m_ol);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the stimulus process stalls.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
